mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM + WB back end of the 5-stage ARM pipeline; drives the write-back inputs of IDSTAGE
//  (write_back_en, dest_wb, reg_data_wb) that feed the register file.
//  Holds the word-addressed data memory, stretches loads/stores by WAIT_STATES cycles via
//  freeze (stalls IF/ID/EXE), and registers the MEM/WB pipeline stage.
// PARAMETERS
//  DEPTH        64    data-memory words
//  ADDR_BITS    6     index width, clog2(DEPTH)
//  BASE_ADDR    1024  byte address of word 0
//  WAIT_STATES  0     extra cycles per memory access (0..15)
// PORTS
//  clk            in   1   clock; all state on rising edge
//  rst            in   1   asynchronous, active-high reset
//  wb_en_in       in   1   EXE/MEM: instruction writes a register
//  mem_read_in    in   1   EXE/MEM: load (LDR)
//  mem_write_in   in   1   EXE/MEM: store (STR)
//  alu_result     in   32  EXE/MEM: ALU result / byte address
//  val_rm         in   32  EXE/MEM: store data
//  dest_in        in   4   EXE/MEM: destination register
//  freeze         out  1   combinational stall request to upstream stages
//  write_back_en  out  1   MEM/WB: register-file write enable to IDSTAGE
//  dest_wb        out  4   MEM/WB: destination register to IDSTAGE
//  reg_data_wb    out  32  MEM/WB: write-back data to IDSTAGE
// BEHAVIOUR
//  - Reset (async, immediate): cnt=0, state IDLE, write_back_en=0, dest_wb=0, reg_data_wb=0;
//    freeze=0 while rst high. Memory array is NOT cleared.
//  - req = mem_read_in | mem_write_in. Upstream holds all inputs stable while freeze=1.
//  - 4-bit counter cnt; state IDLE (cnt==0) / WAIT (cnt!=0).
//    freeze = req & (cnt < WAIT_STATES).
//    Edge, freeze=1: cnt<=cnt+1; no memory write; MEM/WB loads a bubble
//    (write_back_en<=0, dest_wb/reg_data_wb hold).
//    Edge, freeze=0: cnt<=0; access commits; MEM/WB loads the instruction.
//  - Memory op: freeze high exactly WAIT_STATES cycles; it completes on cycle WAIT_STATES+1.
//    WAIT_STATES=0: never freezes; single-cycle memory.
//  - Non-memory instructions (req=0) never freeze; one-cycle pass-through.
//  - Address: off = alu_result - BASE_ADDR; idx = off[ADDR_BITS+1:2]; off[1:0] ignored.
//    In range iff alu_result >= BASE_ADDR and off>>2 < DEPTH.
//  - Store commit (in range): mem[idx] <= val_rm. Out-of-range: no memory change.
//  - MEM/WB load on commit: write_back_en<=wb_en_in; dest_wb<=dest_in;
//    reg_data_wb <= mem_read_in ? (in range ? mem[idx] : 0) : alu_result.
//    Load data is the pre-edge array value (read-before-write).
//  - mem_read_in & mem_write_in together is illegal; it is treated as a store (write wins),
//    and reg_data_wb takes alu_result.
//  - Result latency: 1 cycle after the commit edge (registered outputs).
//  - Back-to-back memory ops each pay the full WAIT_STATES; cnt restarts from 0.
//  - rst during WAIT: access aborted, pending store never written, freeze drops at once.
// TESTING
//  1 W=0: mem_write_in=1, alu_result=1024, val_rm=32'hDEADBEEF; next cycle load 1024,
//    wb_en_in=1, dest_in=4 -> next cycle write_back_en=1, dest_wb=4, reg_data_wb=DEADBEEF; freeze stays 0.
//  2 Pass-through: wb_en_in=1, dest_in=7, alu_result=32'h12345678, req=0
//    -> next cycle write_back_en=1, dest_wb=7, reg_data_wb=12345678.
//  3 W=3: load 1028 holding 32'hA5A5A5A5 -> freeze=1 for exactly 3 cycles,
//    write_back_en=0 during; then write_back_en=1, reg_data_wb=A5A5A5A5.
//  4 Range: stores to 1020 and 1024+4*DEPTH leave memory unchanged; loads there return 0;
//    load 1026 returns the word at 1024.
//  5 W=3: rst pulse in 2nd freeze cycle of store to 1032 (old 32'h1) -> freeze=0 and outputs 0 immediately;
//    later load 1032 returns 32'h1.
//  6 W=2: back-to-back stores to 1036, 1040 -> freeze pattern 1,1,0,1,1,0;
//    both words read back correctly.

Source files
------------

// File: rtl/mem_wb_if.sv
// MEM/WB stage bundle: EXE/MEM inputs, stall request and
// write-back outputs to the register file.
interface mem_wb_if;
  logic        wb_en_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [31:0] alu_result;
  logic [31:0] val_rm;
  logic [3:0]  dest_in;
  logic        freeze;
  logic        write_back_en;
  logic [3:0]  dest_wb;
  logic [31:0] reg_data_wb;

  modport master (
    output wb_en_in, mem_read_in, mem_write_in,
    output alu_result, val_rm, dest_in,
    input  freeze, write_back_en, dest_wb, reg_data_wb
  );

  modport slave (
    input  wb_en_in, mem_read_in, mem_write_in,
    input  alu_result, val_rm, dest_in,
    output freeze, write_back_en, dest_wb, reg_data_wb
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM + WB back end: word data memory with wait-state
// stretching via freeze, plus the MEM/WB pipeline register.
module mem_wb_stage #(
  parameter int DEPTH       = 64,
  parameter int ADDR_BITS   = 6,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic     clk,
  input logic     rst,
  mem_wb_if.slave bus
);

  localparam logic [3:0]  WS      = 4'(WAIT_STATES);
  localparam logic [31:0] BASE    = 32'(BASE_ADDR);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        wb_en_q;
  logic [3:0]  dest_q;
  logic [31:0] data_q;
  logic [31:0] mem_q [DEPTH];

  logic                 req;
  logic                 store;
  logic                 load;
  logic                 more;
  logic                 freeze;
  logic                 in_range;
  logic [29:0]          woff;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          rdata;
  logic [31:0]          wb_data;

  // A simultaneous read+write is treated as a store.
  assign req   = bus.mem_read_in | bus.mem_write_in;
  assign store = bus.mem_write_in;
  assign load  = bus.mem_read_in & ~bus.mem_write_in;

  assign more   = (state_q == IDLE) ? (WS != 4'd0)
                                    : (cnt_q < WS);
  assign freeze = ~rst & req & more;

  assign woff     = bus.alu_result[31:2] - BASE[31:2];
  assign in_range = (bus.alu_result >= BASE)
                 && (woff < DEPTH_W);
  assign idx      = woff[ADDR_BITS-1:0];
  assign rdata    = mem_q[idx];
  assign wb_data  = load ? (in_range ? rdata : '0)
                         : bus.alu_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_en_q <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
    end else if (freeze) begin
      state_q <= WAIT;
      cnt_q   <= cnt_q + 4'd1;
      wb_en_q <= 1'b0;
    end else begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_en_q <= bus.wb_en_in;
      dest_q  <= bus.dest_in;
      data_q  <= wb_data;
    end
  end

  // Array is intentionally not reset; writes only on commit.
  always_ff @(posedge clk) begin
    if (!rst && !freeze && store && in_range)
      mem_q[idx] <= bus.val_rm;
  end

  assign bus.freeze        = freeze;
  assign bus.write_back_en = wb_en_q;
  assign bus.dest_wb       = dest_q;
  assign bus.reg_data_wb   = data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage at WAIT_STATES 0, 3 and 2,
// with a scoreboard of expected write-back results.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_if i0 ();
  mem_wb_if i1 ();
  mem_wb_if i2 ();

  mem_wb_stage #(.WAIT_STATES(0)) u0 (.clk(clk), .rst(rst), .bus(i0));
  mem_wb_stage #(.WAIT_STATES(3)) u1 (.clk(clk), .rst(rst), .bus(i1));
  mem_wb_stage #(.WAIT_STATES(2)) u2 (.clk(clk), .rst(rst), .bus(i2));

  int          sel;
  logic        wb_en, rd, wr;
  logic [31:0] alu, rm;
  logic [3:0]  dest;

  assign i0.wb_en_in     = wb_en & (sel == 0);
  assign i0.mem_read_in  = rd    & (sel == 0);
  assign i0.mem_write_in = wr    & (sel == 0);
  assign i0.alu_result   = alu   & {32{sel == 0}};
  assign i0.val_rm       = rm    & {32{sel == 0}};
  assign i0.dest_in      = dest  & {4{sel == 0}};
  assign i1.wb_en_in     = wb_en & (sel == 1);
  assign i1.mem_read_in  = rd    & (sel == 1);
  assign i1.mem_write_in = wr    & (sel == 1);
  assign i1.alu_result   = alu   & {32{sel == 1}};
  assign i1.val_rm       = rm    & {32{sel == 1}};
  assign i1.dest_in      = dest  & {4{sel == 1}};
  assign i2.wb_en_in     = wb_en & (sel == 2);
  assign i2.mem_read_in  = rd    & (sel == 2);
  assign i2.mem_write_in = wr    & (sel == 2);
  assign i2.alu_result   = alu   & {32{sel == 2}};
  assign i2.val_rm       = rm    & {32{sel == 2}};
  assign i2.dest_in      = dest  & {4{sel == 2}};

  logic        frz, owb;
  logic [3:0]  odst;
  logic [31:0] odat;

  always_comb begin
    frz  = i0.freeze;
    owb  = i0.write_back_en;
    odst = i0.dest_wb;
    odat = i0.reg_data_wb;
    if (sel == 1) begin
      frz  = i1.freeze;
      owb  = i1.write_back_en;
      odst = i1.dest_wb;
      odat = i1.reg_data_wb;
    end else if (sel == 2) begin
      frz  = i2.freeze;
      owb  = i2.write_back_en;
      odst = i2.dest_wb;
      odat = i2.reg_data_wb;
    end
  end

  typedef struct packed {
    logic        wb;
    logic [3:0]  d;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after commit.
  task automatic issue(input string tag, input logic w, r, s,
                       input logic [31:0] a, v, input logic [3:0] d,
                       input int efz, input logic [31:0] edata);
    int   n;
    exp_t e;
    wb_en = w; rd = r; wr = s; alu = a; rm = v; dest = d;
    n = 0;
    #1;
    while (frz && n < 20) begin
      @(posedge clk); #1;
      chk({tag, ".stall_wb"}, 32'(owb), 32'd0);
      @(negedge clk); #1;
      n++;
    end
    chk({tag, ".freeze_cycles"}, 32'(n), 32'(efz));
    sb.push_back('{wb: w, d: d, data: edata});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, ".wb_en"}, 32'(owb), 32'(e.wb));
    chk({tag, ".dest"}, 32'(odst), 32'(e.d));
    chk({tag, ".data"}, odat, e.data);
    @(negedge clk);
  endtask

  task automatic idle();
    wb_en = 0; rd = 0; wr = 0; alu = '0; rm = '0; dest = '0;
  endtask

  initial begin
    idle();
    sel = 1;
    rst = 1'b1;
    rd  = 1'b1;
    #1;
    chk("reset.freeze", 32'(frz), 32'd0);
    chk("reset.wb_en", 32'(owb), 32'd0);
    chk("reset.dest", 32'(odst), 32'd0);
    chk("reset.data", odat, 32'd0);
    @(negedge clk);
    @(negedge clk);
    idle();
    rst = 1'b0;

    // W=0: store then load, then pass-through
    sel = 0;
    issue("t1.st", 0, 0, 1, 1024, 32'hDEADBEEF, 0, 0, 1024);
    issue("t1.ld", 1, 1, 0, 1024, 0, 4, 0, 32'hDEADBEEF);
    issue("t2.pass", 1, 0, 0, 32'h12345678, 0, 7, 0, 32'h12345678);

    // Range boundaries
    issue("t4.st_top", 0, 0, 1, 1276, 32'h11111111, 0, 0, 1276);
    issue("t4.st_lo", 0, 0, 1, 1020, 32'h22222222, 0, 0, 1020);
    issue("t4.st_hi", 0, 0, 1, 1280, 32'h33333333, 0, 0, 1280);
    issue("t4.ld_base", 1, 1, 0, 1024, 0, 1, 0, 32'hDEADBEEF);
    issue("t4.ld_top", 1, 1, 0, 1276, 0, 2, 0, 32'h11111111);
    issue("t4.ld_lo", 1, 1, 0, 1020, 0, 3, 0, 32'h0);
    issue("t4.ld_hi", 1, 1, 0, 1280, 0, 5, 0, 32'h0);
    issue("t4.ld_unal", 1, 1, 0, 1026, 0, 6, 0, 32'hDEADBEEF);
    issue("ill.rw", 1, 1, 1, 1024, 32'hCAFEF00D, 2, 0, 1024);
    issue("ill.ld", 1, 1, 0, 1024, 0, 8, 0, 32'hCAFEF00D);
    idle();

    // W=3: stretched store/load, pass-through
    sel = 1;
    issue("t3.st", 0, 0, 1, 1028, 32'hA5A5A5A5, 0, 3, 1028);
    issue("t3.ld", 1, 1, 0, 1028, 0, 9, 3, 32'hA5A5A5A5);
    issue("t3.pass", 1, 0, 0, 32'h00C0FFEE, 0, 10, 0, 32'h00C0FFEE);

    // W=3: reset aborts a pending store
    issue("t5.st_old", 1, 0, 1, 1032, 32'h1, 5, 3, 1032);
    wb_en = 1; rd = 0; wr = 1; alu = 1032; rm = 32'hFFFFFFFF; dest = 11;
    #1;
    chk("t5.frz1", 32'(frz), 32'd1);
    @(posedge clk);
    @(negedge clk); #1;
    chk("t5.frz2", 32'(frz), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5.rst_freeze", 32'(frz), 32'd0);
    chk("t5.rst_wb", 32'(owb), 32'd0);
    chk("t5.rst_dest", 32'(odst), 32'd0);
    chk("t5.rst_data", odat, 32'd0);
    idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue("t5.ld", 1, 1, 0, 1032, 0, 12, 3, 32'h1);
    idle();

    // W=2: back-to-back stores
    sel = 2;
    issue("t6.st1", 0, 0, 1, 1036, 32'h0BADF00D, 0, 2, 1036);
    issue("t6.st2", 0, 0, 1, 1040, 32'h600DCAFE, 0, 2, 1040);
    issue("t6.ld1", 1, 1, 0, 1036, 0, 13, 2, 32'h0BADF00D);
    issue("t6.ld2", 1, 1, 0, 1040, 0, 14, 2, 32'h600DCAFE);
    idle();

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
